// File: rtl/pipelined_shifter_pkg.sv
// shifter_pkg: shared types for pipelined_shifter.
//   shift_type_e : operation encoding carried on in_type.
//   stage_reg_t  : contents of one pipeline stage register. Fields are sized
//                  for the largest supported configuration (N = 64); narrower
//                  builds use the low bits and keep the upper bits at zero,
//                  which synthesis removes as constants.
package shifter_pkg;

  typedef enum logic [1:0] {
    SRL = 2'b00,
    SLL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_type_e;

  localparam int MAX_N       = 64;
  localparam int MAX_SHAMT_W = 6;
  localparam int MAX_TAG_W   = 16;

  typedef struct packed {
    logic                   valid;
    logic [MAX_N-1:0]       data;
    logic [MAX_SHAMT_W-1:0] shamt;
    shift_type_e            op;
    logic                   sign;
    logic [MAX_TAG_W-1:0]   tag;
  } stage_reg_t;

endpackage

// File: rtl/pipelined_shifter_if.sv
// shifter_if: request/result handshake bundle of pipelined_shifter.
//   in_valid/in_ready, in_a, in_shamt, in_type (2'b00 SRL, 01 SLL, 10 SRA,
//   11 ROR), in_tag : request side.
//   out_valid/out_ready, out_r, out_tag : result side.
//   modport master : requester / result consumer.
//   modport slave  : the shifter.
interface shifter_if #(
  parameter int N     = 32,
  parameter int TAG_W = 5
);
  localparam int SHAMT_W = $clog2(N);

  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_a;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_type;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_r;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_shamt, in_type, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_shamt, in_type, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag
  );

endinterface

// File: rtl/pipelined_shifter_shift_stage.sv
// shift_stage: one log-shifter level of pipelined_shifter plus its register.
//   Shifts the incoming operand by 2^K when shamt bit K is set.
//   Optional feature macro: SHIFTER_ROTATE_EN (enables the ROR wraparound mux;
//   without it ROR passes data through unchanged).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset.
//   flush       : synchronous clear of the valid bit.
//   up          : upstream stage contents (or the entry request for K = 0).
//   up_ready    : this stage can load this cycle.
//   down_ready  : downstream stage can load (out_ready for the last stage).
//   q           : registered stage contents.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 5,
  parameter int K     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  stage_reg_t up,
  output logic       up_ready,
  input  logic       down_ready,
  output stage_reg_t q
);

  localparam int AMT = 1 << K;

  logic [N-1:0] d;
  logic [N-1:0] shifted;
  stage_reg_t   nxt;

  always_comb begin
    d       = up.data[N-1:0];
    shifted = d;
    if (up.shamt[K]) begin
      case (up.op)
        SRL: shifted = d >> AMT;
        SLL: shifted = d << AMT;
        // Fill from the sign captured at entry, not from the current MSB.
        SRA: shifted = {{AMT{up.sign}}, d[N-1:AMT]};
        ROR: begin
`ifdef SHIFTER_ROTATE_EN
          shifted = {d[AMT-1:0], d[N-1:AMT]};
`else
          shifted = d;
`endif
        end
        default: shifted = d;
      endcase
    end
  end

  always_comb begin
    nxt              = up;
    nxt.data[N-1:0]  = shifted;
  end

  // Load when empty or when the current occupant moves on this cycle.
  assign up_ready = !q.valid || down_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (up_ready) begin
      q.valid <= up.valid;
      // Payload only changes with a real operation so it stays quiet on bubbles.
      if (up.valid) begin
        q <= nxt;
      end
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: L = $clog2(N) stage elastic barrel shifter (SRL, SLL,
// SRA, optional ROR) with valid/ready handshake, passthrough tag and flush.
//   Optional feature macro: SHIFTER_ROTATE_EN (in_type 2'b11 rotates right;
//   undefined, in_type 2'b11 returns in_a unchanged).
// Ports:
//   clk   : rising-edge clock.
//   rst_n : asynchronous active-low reset.
//   flush : synchronous squash of all in-flight operations.
//   bus   : shifter_if slave (request and result handshakes).
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  shifter_if.slave  bus
);

  localparam int L = $clog2(N);

  stage_reg_t entry;
  stage_reg_t stg [L];
  logic       rdy [L+1];

  always_comb begin
    entry               = '0;
    entry.valid         = bus.in_valid && !flush;
    entry.data[N-1:0]   = bus.in_a;
    entry.shamt[L-1:0]  = bus.in_shamt;
    entry.op            = shift_type_e'(bus.in_type);
    entry.sign          = bus.in_a[N-1];
    entry.tag[TAG_W-1:0] = bus.in_tag;
  end

  assign rdy[L] = bus.out_ready;

  for (genvar k = 0; k < L; k++) begin : g_stage
    stage_reg_t up_k;
    if (k == 0) begin : g_first
      assign up_k = entry;
    end else begin : g_rest
      assign up_k = stg[k-1];
    end

    shift_stage #(
      .N     (N),
      .TAG_W (TAG_W),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .up         (up_k),
      .up_ready   (rdy[k]),
      .down_ready (rdy[k+1]),
      .q          (stg[k])
    );
  end

  assign bus.in_ready  = rdy[0] && !flush;
  assign bus.out_valid = stg[L-1].valid;
  assign bus.out_r     = stg[L-1].data[N-1:0];
  assign bus.out_tag   = stg[L-1].tag[TAG_W-1:0];

  // The last stage's shamt/op/sign and padding bits have no consumer.
  logic unused_last;
  assign unused_last = ^stg[L-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;
  localparam int N     = 32;
  localparam int TAG_W = 5;
  localparam logic [1:0] T_SRL = 2'b00;
  localparam logic [1:0] T_SLL = 2'b01;
  localparam logic [1:0] T_SRA = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shifter_if #(.N(N), .TAG_W(TAG_W)) bus ();

  pipelined_shifter #(.N(N), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] sh,
                       input logic [1:0] ty, input logic [4:0] tg);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_shamt = sh;
    bus.in_type  = ty;
    bus.in_tag   = tg;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [4:0] sh,
                         input logic [1:0] ty, input logic [4:0] tg, input logic [31:0] exp_r);
    int cyc;
    bus.out_ready = 1'b1;
    drive(1'b1, a, sh, ty, tg);
    step();
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc !== 5) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, expected 5", name, cyc);
    end
    checks++;
    if (bus.out_r !== exp_r) begin
      failures++;
      $display("FAIL %s out_r: got %h, expected %h", name, bus.out_r, exp_r);
    end
    checks++;
    if (bus.out_tag !== tg) begin
      failures++;
      $display("FAIL %s out_tag: got %0d, expected %0d", name, bus.out_tag, tg);
    end
    step();
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 5'd0, T_SRL, 5'd0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset out_valid: got %b, expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_r !== 32'h0) begin
      failures++;
      $display("FAIL reset out_r: got %h, expected 0", bus.out_r);
    end
    checks++;
    if (bus.out_tag !== 5'd0) begin
      failures++;
      $display("FAIL reset out_tag: got %0d, expected 0", bus.out_tag);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset in_ready: got %b, expected 1", bus.in_ready);
    end
  endtask

  task automatic test_shifts();
    run_one("sra_neg",   32'h8000_0000, 5'd4,  T_SRA, 5'd7,  32'hF800_0000);
    run_one("srl",       32'h8000_0000, 5'd4,  T_SRL, 5'd1,  32'h0800_0000);
    run_one("sll_31",    32'h0000_0001, 5'd31, T_SLL, 5'd2,  32'h8000_0000);
    run_one("sra_pos",   32'h7000_0000, 5'd4,  T_SRA, 5'd3,  32'h0700_0000);
    run_one("sra_31",    32'hF000_0000, 5'd31, T_SRA, 5'd4,  32'hFFFF_FFFF);
    run_one("srl_12",    32'hDEAD_BEEF, 5'd12, T_SRL, 5'd5,  32'h000D_EADB);
    run_one("srl_0",     32'hDEAD_BEEF, 5'd0,  T_SRL, 5'd6,  32'hDEAD_BEEF);
    run_one("sll_0",     32'hDEAD_BEEF, 5'd0,  T_SLL, 5'd8,  32'hDEAD_BEEF);
    run_one("sra_0",     32'hDEAD_BEEF, 5'd0,  T_SRA, 5'd9,  32'hDEAD_BEEF);
    run_one("ror_0",     32'hDEAD_BEEF, 5'd0,  T_ROR, 5'd10, 32'hDEAD_BEEF);
  endtask

  task automatic test_rotate();
`ifdef SHIFTER_ROTATE_EN
    run_one("ror_4", 32'h0000_00F1, 5'd4, T_ROR, 5'd11, 32'h1000_000F);
`else
    run_one("ror_4", 32'h0000_00F1, 5'd4, T_ROR, 5'd11, 32'h0000_00F1);
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_r [5] = '{32'h0000_0003, 32'h0000_0018, 32'h0000_00C0,
                               32'h0000_0600, 32'h0000_3000};
    int acc;
    acc = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h0000_0003, 5'(acc * 3), T_SLL, 5'(10 + acc));
      #1;
      if (bus.in_ready) acc++;
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (acc !== 5) begin
      failures++;
      $display("FAIL bp accepted: got %0d, expected 5", acc);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp in_ready full: got %b, expected 0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp in_ready release: got %b, expected 1", bus.in_ready);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'(10 + j) || bus.out_r !== exp_r[j]) begin
        failures++;
        $display("FAIL bp drain %0d: valid=%b tag=%0d r=%h, expected valid=1 tag=%0d r=%h",
                 j, bus.out_valid, bus.out_tag, bus.out_r, 10 + j, exp_r[j]);
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp empty: got out_valid %b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [6] = '{32'hF000_0000, 32'h7800_0000, 32'h3C00_0000,
                               32'h1E00_0000, 32'h0F00_0000, 32'h0780_0000};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) drive(1'b1, 32'hF000_0000, 5'(c), T_SRL, 5'(c));
      else bus.in_valid = 1'b0;
      #1;
      if (c < 6) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b in_ready %0d: got %b, expected 1", c, bus.in_ready);
        end
      end
      if (c >= 5 && c <= 10) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'(c - 5) || bus.out_r !== exp_r[c-5]) begin
          failures++;
          $display("FAIL b2b result %0d: valid=%b tag=%0d r=%h, expected valid=1 tag=%0d r=%h",
                   c - 5, bus.out_valid, bus.out_tag, bus.out_r, c - 5, exp_r[c-5]);
        end
      end
      if (c == 11) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b empty: got out_valid %b, expected 0", bus.out_valid);
        end
      end
      step();
    end
  endtask

  task automatic test_flush();
    int seen;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0000_0001, 5'd1, T_SLL, 5'd1);
    step();
    drive(1'b1, 32'h0000_0001, 5'd2, T_SLL, 5'd2);
    step();
    drive(1'b1, 32'h0000_0001, 5'd3, T_SLL, 5'd3);
    step();
    drive(1'b1, 32'h0000_0001, 5'd4, T_SLL, 5'd4);
    flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush in_ready: got %b, expected 0", bus.in_ready);
    end
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL flush squash: got %0d valid cycles, expected 0", seen);
    end
    run_one("after_flush", 32'h0000_0005, 5'd2, T_SLL, 5'd9, 32'h0000_0014);
  endtask

  task automatic test_reset_midflight();
    int seen;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0000_00FF, 5'd8, T_SLL, 5'd21);
    step();
    drive(1'b1, 32'h0000_00FF, 5'd4, T_SLL, 5'd22);
    step();
    drive(1'b1, 32'h0000_00FF, 5'd1, T_SLL, 5'd23);
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_r !== 32'h0000_FF00 || bus.out_tag !== 5'd21) begin
      failures++;
      $display("FAIL midrst pre: valid=%b r=%h tag=%0d, expected valid=1 r=0000ff00 tag=21",
               bus.out_valid, bus.out_r, bus.out_tag);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_r !== 32'h0 || bus.out_tag !== 5'd0) begin
      failures++;
      $display("FAIL midrst async: valid=%b r=%h tag=%0d, expected all 0",
               bus.out_valid, bus.out_r, bus.out_tag);
    end
    repeat (2) step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst in_ready: got %b, expected 1", bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midrst stale: got %0d valid cycles, expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_rotate();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
